// File: rtl/nmos_pass_array_if.sv
// Bundle of per-channel drain/gate inputs and registered source/state outputs
// shared by a group of NMOS pass gates.
interface nmos_pass_array_if #(
   parameter int unsigned CH = 8
);
   logic          en;
   real           vd [CH];
   real           vg [CH];
   real           vs [CH];
   logic [CH-1:0] on;
   logic [CH-1:0] flt;

   modport master (output en, vd, vg, input vs, on, flt);
   modport slave  (input en, vd, vg, output vs, on, flt);
endinterface

// File: rtl/nmos_pass_array.sv
// Array of CH independent clocked real-valued NMOS pass gates with optional
// threshold drop and a charge-retention mode in which a floating node leaks
// toward VSS one step every LEAK_CYC enabled cycles.
module nmos_pass_array #(
   parameter int unsigned CH        = 8,
   parameter real         VDD       = 1.5,
   parameter real         VSS       = 0.0,
   parameter real         VTH       = 0.8,
   parameter int unsigned VT_DROP   = 0,
   parameter int unsigned MODE      = 0,
   parameter int unsigned LEAK_CYC  = 4,
   parameter real         LEAK_STEP = 0.1
) (
   input logic         clk,
   input logic         rst,
   nmos_pass_array_if.slave bus
);

   // Repeated subtraction of LEAK_STEP leaves tiny residues; anything this
   // close to VSS is treated as fully discharged.
   localparam real         EPS      = 1.0e-9;
   localparam int unsigned CW       = (LEAK_CYC > 1) ? $clog2(LEAK_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LEAK_CYC - 1);

   typedef enum logic [1:0] {StOff, StOn, StHold} state_e;

   state_e        state_q [CH];
   real           vs_q    [CH];
   logic [CW-1:0] cnt_q   [CH];

   logic conduct [CH];
   logic cut     [CH];
   real  drive   [CH];
   real  decay   [CH];

   // Per-channel conduction conditions, clamped drive value and next leak level.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         conduct[i] = (bus.vg[i] >= VTH) && (bus.vd[i] >= VTH);
         cut[i]     = (bus.vg[i] < VTH);
         drive[i]   = bus.vd[i];
         if ((VT_DROP != 0) && ((bus.vg[i] - VTH) < drive[i])) begin
            drive[i] = bus.vg[i] - VTH;
         end
         if (drive[i] > VDD) begin
            drive[i] = VDD;
         end
         if (drive[i] < VSS) begin
            drive[i] = VSS;
         end
         decay[i] = vs_q[i] - LEAK_STEP;
         if (decay[i] <= VSS + EPS) begin
            decay[i] = VSS;
         end
      end
   end

   // Channel state machines: reset, freeze on !en, conduct wins over leakage.
   always_ff @(posedge clk) begin
      for (int i = 0; i < CH; i++) begin
         if (rst) begin
            state_q[i] <= StOff;
            vs_q[i]    <= VSS;
            cnt_q[i]   <= '0;
         end else if (bus.en) begin
            if (conduct[i]) begin
               state_q[i] <= StOn;
               vs_q[i]    <= drive[i];
               cnt_q[i]   <= '0;
            end else if (MODE == 0) begin
               cnt_q[i] <= '0;
               if (cut[i]) begin
                  state_q[i] <= StOff;
                  vs_q[i]    <= VSS;
               end else begin
                  state_q[i] <= StHold;
               end
            end else if ((state_q[i] != StOff) && (vs_q[i] > VSS + EPS)) begin
               if (cnt_q[i] == CNT_LAST) begin
                  cnt_q[i] <= '0;
                  vs_q[i]  <= decay[i];
                  state_q[i] <= (decay[i] <= VSS + EPS) ? StOff : StHold;
               end else begin
                  cnt_q[i]   <= cnt_q[i] + 1'b1;
                  state_q[i] <= StHold;
               end
            end else begin
               state_q[i] <= StOff;
               vs_q[i]    <= VSS;
               cnt_q[i]   <= '0;
            end
         end
      end
   end

   // Outputs are decoded straight from the registered channel state.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         bus.vs[i]  = vs_q[i];
         bus.on[i]  = (state_q[i] == StOn);
         bus.flt[i] = (state_q[i] == StHold);
      end
   end

endmodule

// File: tb/tb_nmos_pass_array.sv
// Bench for nmos_pass_array: three instances (legacy, threshold-drop,
// charge-retention) driven by directed steps; expected outputs are queued
// when inputs are applied and checked one edge later.
module tb_nmos_pass_array;

   localparam int CH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   nmos_pass_array_if #(.CH(CH)) if_leg ();
   nmos_pass_array_if #(.CH(CH)) if_vt  ();
   nmos_pass_array_if #(.CH(CH)) if_ret ();

   nmos_pass_array #(.CH(CH), .VT_DROP(0), .MODE(0)) u_leg (
      .clk (clk),
      .rst (rst),
      .bus (if_leg)
   );

   nmos_pass_array #(.CH(CH), .VT_DROP(1), .MODE(0)) u_vt (
      .clk (clk),
      .rst (rst),
      .bus (if_vt)
   );

   nmos_pass_array #(.CH(CH), .VT_DROP(0), .MODE(1), .LEAK_CYC(4), .LEAK_STEP(0.1)) u_ret (
      .clk (clk),
      .rst (rst),
      .bus (if_ret)
   );

   typedef struct {
      string tag;
      int    d;
      int    ch;
      int    mv;
      bit    on;
      bit    flt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic int to_mv(real v);
      return (v >= 0.0) ? $rtoi(v * 1000.0 + 0.5) : $rtoi(v * 1000.0 - 0.5);
   endfunction

   task automatic set_ch(input int d, input int ch, input real vd, input real vg);
      case (d)
         0: begin if_leg.vd[ch] = vd; if_leg.vg[ch] = vg; end
         1: begin if_vt.vd[ch]  = vd; if_vt.vg[ch]  = vg; end
         default: begin if_ret.vd[ch] = vd; if_ret.vg[ch] = vg; end
      endcase
   endtask

   task automatic set_all(input int d, input real vd, input real vg);
      for (int i = 0; i < CH; i++) set_ch(d, i, vd, vg);
   endtask

   task automatic set_en(input int d, input logic e);
      case (d)
         0:       if_leg.en = e;
         1:       if_vt.en  = e;
         default: if_ret.en = e;
      endcase
   endtask

   task automatic obs(input int d, input int ch, output int mv, output bit on, output bit flt);
      case (d)
         0:       begin mv = to_mv(if_leg.vs[ch]); on = if_leg.on[ch]; flt = if_leg.flt[ch]; end
         1:       begin mv = to_mv(if_vt.vs[ch]);  on = if_vt.on[ch];  flt = if_vt.flt[ch];  end
         default: begin mv = to_mv(if_ret.vs[ch]); on = if_ret.on[ch]; flt = if_ret.flt[ch]; end
      endcase
   endtask

   task automatic expect_ch(input string tag, input int d, input int ch, input int mv,
                            input bit on, input bit flt);
      exp_t e;
      e.tag = tag; e.d = d; e.ch = ch; e.mv = mv; e.on = on; e.flt = flt;
      sb.push_back(e);
   endtask

   task automatic expect_all(input string tag, input int d, input int mv, input bit on,
                             input bit flt);
      for (int i = 0; i < CH; i++) expect_ch(tag, d, i, mv, on, flt);
   endtask

   // Advance one edge, then drain the scoreboard against the settled outputs.
   task automatic tick();
      exp_t e;
      int   mv;
      bit   on;
      bit   flt;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs(e.d, e.ch, mv, on, flt);
         n_cmp++;
         assert (mv === e.mv) else begin
            n_fail++;
            $error("FAIL %s d%0d ch%0d vs: got %0d mV, want %0d mV", e.tag, e.d, e.ch, mv, e.mv);
         end
         n_cmp++;
         assert (on === e.on) else begin
            n_fail++;
            $error("FAIL %s d%0d ch%0d on: got %0b, want %0b", e.tag, e.d, e.ch, on, e.on);
         end
         n_cmp++;
         assert (flt === e.flt) else begin
            n_fail++;
            $error("FAIL %s d%0d ch%0d flt: got %0b, want %0b", e.tag, e.d, e.ch, flt, e.flt);
         end
      end
   endtask

   initial begin
      int others [4];
      int m;
      others = '{1, 2, 4, 7};

      // Reset held two cycles with every channel biased fully on.
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         set_en(d, 1'b1);
         set_all(d, 1.5, 1.5);
      end
      repeat (2) begin
         for (int d = 0; d < 3; d++) expect_all("reset", d, 0, 1'b0, 1'b0);
         tick();
      end
      rst = 1'b0;
      expect_all("post_rst_leg", 0, 1500, 1'b1, 1'b0);
      expect_all("post_rst_vt",  1, 700,  1'b1, 1'b0);
      expect_all("post_rst_ret", 2, 1500, 1'b1, 1'b0);
      tick();

      // Legacy switch, rail clamp and threshold-drop cases.
      set_ch(0, 0, 1.2, 1.5);
      set_ch(0, 1, 2.0, 2.0);
      set_ch(1, 0, 1.5, 1.0);
      set_ch(1, 2, 1.0, 2.0);
      expect_ch("leg_conduct", 0, 0, 1200, 1'b1, 1'b0);
      expect_ch("leg_clamp",   0, 1, 1500, 1'b1, 1'b0);
      expect_ch("leg_other",   0, 7, 1500, 1'b1, 1'b0);
      expect_ch("vt_drop",     1, 0, 200,  1'b1, 1'b0);
      expect_ch("vt_min_vd",   1, 2, 1000, 1'b1, 1'b0);
      expect_ch("vt_full",     1, 1, 700,  1'b1, 1'b0);
      tick();

      set_ch(0, 0, 0.5, 1.5);
      set_ch(0, 2, -0.3, 1.5);
      expect_ch("leg_stall",   0, 0, 1200, 1'b0, 1'b1);
      expect_ch("leg_neg_vd",  0, 2, 1500, 1'b0, 1'b1);
      expect_ch("vt_steady",   1, 0, 200,  1'b1, 1'b0);
      tick();

      set_ch(0, 0, 0.5, 0.3);
      expect_ch("leg_cut",     0, 0, 0,    1'b0, 1'b0);
      expect_ch("leg_hold2",   0, 2, 1500, 1'b0, 1'b1);
      tick();

      set_en(0, 1'b0);
      set_ch(0, 0, 1.2, 1.5);
      set_ch(0, 2, 1.5, 0.0);
      expect_ch("leg_en0_a",   0, 0, 0,    1'b0, 1'b0);
      expect_ch("leg_en0_b",   0, 2, 1500, 1'b0, 1'b1);
      tick();

      set_en(0, 1'b1);
      set_ch(0, 4, 0.8, 0.8);
      set_ch(1, 3, 1.5, 0.8);
      expect_ch("leg_en1",     0, 0, 1200, 1'b1, 1'b0);
      expect_ch("leg_cut2",    0, 2, 0,    1'b0, 1'b0);
      expect_ch("leg_vth_edge", 0, 4, 800, 1'b1, 1'b0);
      expect_ch("vt_vg_eq_vth", 1, 3, 0,   1'b1, 1'b0);
      tick();

      // Retention: fresh reset with everything cut.
      rst = 1'b1;
      set_all(2, 0.0, 0.0);
      expect_all("ret_reset", 2, 0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      set_ch(2, 0, 1.0, 1.5);
      set_ch(2, 3, 1.5, 1.5);
      set_ch(2, 5, 0.8, 1.5);
      set_ch(2, 6, 1.0, 1.5);
      expect_ch("ret_load0", 2, 0, 1000, 1'b1, 1'b0);
      expect_ch("ret_load3", 2, 3, 1500, 1'b1, 1'b0);
      expect_ch("ret_load5", 2, 5, 800,  1'b1, 1'b0);
      expect_ch("ret_load6", 2, 6, 1000, 1'b1, 1'b0);
      foreach (others[k]) expect_ch("ret_load_off", 2, others[k], 0, 1'b0, 1'b0);
      tick();

      // ch0 cut, ch5 stalled, ch6 re-driven when its counter sits at 3.
      set_ch(2, 0, 1.0, 0.0);
      set_ch(2, 5, 0.0, 1.5);
      set_ch(2, 6, 1.0, 0.0);
      for (int n = 1; n <= 44; n++) begin
         if (n == 4) set_ch(2, 6, 1.3, 1.5);
         if (n >= 40) expect_ch("leak_ch0", 2, 0, 0, 1'b0, 1'b0);
         else         expect_ch("leak_ch0", 2, 0, 1000 - 100 * (n / 4), 1'b0, 1'b1);
         if (n >= 32) expect_ch("leak_ch5", 2, 5, 0, 1'b0, 1'b0);
         else         expect_ch("leak_ch5", 2, 5, 800 - 100 * (n / 4), 1'b0, 1'b1);
         if (n < 4)   expect_ch("redrive_ch6", 2, 6, 1000, 1'b0, 1'b1);
         else         expect_ch("redrive_ch6", 2, 6, 1300, 1'b1, 1'b0);
         expect_ch("indep_ch3", 2, 3, 1500, 1'b1, 1'b0);
         foreach (others[k]) expect_ch("indep_off", 2, others[k], 0, 1'b0, 1'b0);
         tick();
      end

      // Same decay with en low for edges 6..10: every step shifts by 5.
      set_ch(2, 0, 1.0, 1.5);
      expect_ch("gap_load", 2, 0, 1000, 1'b1, 1'b0);
      tick();
      set_ch(2, 0, 1.0, 0.0);
      for (int n = 1; n <= 46; n++) begin
         if (n == 6) begin
            set_en(2, 1'b0);
            set_ch(2, 3, 1.2, 1.5);
         end
         if (n == 11) begin
            set_en(2, 1'b1);
            set_ch(2, 3, 1.5, 1.5);
         end
         m = (n <= 5) ? n : ((n <= 10) ? 5 : n - 5);
         if (m >= 40) expect_ch("gap_ch0", 2, 0, 0, 1'b0, 1'b0);
         else         expect_ch("gap_ch0", 2, 0, 1000 - 100 * (m / 4), 1'b0, 1'b1);
         expect_ch("gap_ch3", 2, 3, 1500, 1'b1, 1'b0);
         tick();
      end

      // Reset while holding charge discards it.
      set_ch(2, 0, 1.0, 1.5);
      expect_ch("rsthold_load", 2, 0, 1000, 1'b1, 1'b0);
      tick();
      set_ch(2, 0, 1.0, 0.0);
      repeat (2) begin
         expect_ch("rsthold_hold", 2, 0, 1000, 1'b0, 1'b1);
         tick();
      end
      rst = 1'b1;
      expect_ch("rsthold_rst0", 2, 0, 0, 1'b0, 1'b0);
      expect_ch("rsthold_rst3", 2, 3, 0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      repeat (5) begin
         expect_ch("rsthold_after0", 2, 0, 0,    1'b0, 1'b0);
         expect_ch("rsthold_after3", 2, 3, 1500, 1'b1, 1'b0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
